readback_scheduler: RTL
=======================

Name: readback_scheduler

Overview:
- Shares the single core->Jetson readback channel (the SPI link's write-side FIFO input) between up to 8 status/sensor modules.
- Each requester gets a one-word holding register, so a pulse request is never lost while the link is busy.
- A grant state machine picks one word at a time using three levels: urgent-class channels first, then aged channels, then round-robin.
- Also drives the Jetson "urgent" GPIO and reports sticky per-channel overflow.

Parameters:
- CHANNELS, 6, number of requesters (1..8).
- WIDTH, 28, payload width per channel.
- URGENT_MASK, 6'b000010, bit i=1 puts channel i in the urgent class.
- AGE_LIMIT, 255, cycles a pending non-urgent word waits before it is promoted (1..255, 8-bit counter).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  CHANNELS  per-channel capture strobe; a single-cycle pulse.
- bus_in  in  CHANNELS*WIDTH  channel i payload at bus_in[i*WIDTH +: WIDTH]; valid only while req[i]=1.
- busy  out  CHANNELS  channel holding register occupied.
- out_data  out  WIDTH  granted payload.
- out_sel  out  3  granted channel index.
- out_stb  out  1  word offered to the link.
- out_rdy  in  1  link accepts; a transfer occurs when out_stb&&out_rdy in the same cycle.
- urgent  out  1  at least one urgent-class word is pending.
- overflow  out  CHANNELS  sticky: a request arrived while its channel was full.
- ovf_clr  in  1  clears all overflow bits.

Behaviour:
- Reset values:
  - busy, out_data, out_sel, out_stb, urgent, overflow, all age counters = 0.
  - Round-robin pointer = CHANNELS-1, so channel 0 is first.
  - FSM state = IDLE.
  - Asserting rst mid-offer drops the word immediately and forces out_stb low.
- Capture:
  - req[i] with busy[i]=0 latches the payload; busy[i]=1 from the next cycle.
  - req[i] in the same cycle that channel i's word transfers also latches the new payload. busy[i] stays 1 and there is no overflow.
  - req[i] with busy[i]=1 and no transfer on i: the payload is discarded and overflow[i] is set (sticky).
  - A set of overflow[i] in the same cycle as ovf_clr wins: that bit ends at 1.
- Aging:
  - Per-channel 8-bit counter increments each cycle busy[i]=1 while channel i is not the word on offer.
  - The counter saturates at AGE_LIMIT and clears when busy[i]=0.
  - A channel is "aged" when its count equals AGE_LIMIT.
- FSM IDLE:
  - If no busy bit is set, stay in IDLE.
  - Otherwise select a winner, in priority order:
    - (a) the lowest-index busy urgent-class channel;
    - (b) else the lowest-index busy aged channel;
    - (c) else the first busy channel after the round-robin pointer, with wrap-around.
  - Register the winner's holding data into out_data and its index into out_sel; set out_stb=1; go to OFFER.
- FSM OFFER:
  - out_stb, out_data and out_sel are held stable until a transfer.
  - On transfer:
    - clear busy of the winner, unless it is re-captured the same cycle;
    - the round-robin pointer becomes the winner index, but only for grants under (c). Grants under (a) and (b) leave the pointer unchanged;
    - out_stb=0 the next cycle; go to IDLE.
  - No pre-emption: a newly arriving urgent word waits for the current offer to complete.
- Timing:
  - Latency: req at cycle t -> busy at t+1 -> out_stb at t+2 (with out_rdy=1, and the FSM in IDLE at t+1).
  - Sustained throughput is one word per 2 cycles: one bubble cycle in IDLE after each transfer.
- urgent output:
  - Registered: equals OR(busy & URGENT_MASK) delayed by one cycle.
- Width rules:
  - out_sel is 3 bits regardless of CHANNELS; unused upper bits are 0.
  - Index comparisons are done modulo CHANNELS.

Test Plan:
- Reset, then a single req[3] with payload 28'h0ABCDEF and out_rdy=1 -> busy[3]=1 at t+1; out_stb=1, out_sel=3, out_data=0ABCDEF at t+2; busy[3]=0 at t+3.
- req on channels 0, 2 and 4 in the same cycle, all non-urgent -> grants in order 0, 2, 4, with out_stb pulses 2 cycles apart.
- With channels 0 and 2 pending, pulse req[1] (urgent) while channel 0 is on offer -> channel 0 completes, then 1, then 2; urgent goes high 2 cycles after req[1] and falls 2 cycles after req[1] was captured once channel 1's word is gone.
- Hold out_rdy=0 for 300 cycles while channel 0 is offered and channel 5 is pending -> out_data and out_sel stay stable throughout; channel 5's age counter saturates at 255; with a pending channel 3 added later, channel 5 is granted before channel 3 once out_rdy=1.
- req[2] twice, 1 cycle apart, with out_rdy=0 -> overflow[2]=1 and the first payload is kept. Pulse ovf_clr together with a third colliding req[2] -> overflow[2] stays 1. A lone ovf_clr -> overflow[2]=0.
- Assert rst during OFFER -> out_stb, busy and urgent all 0 asynchronously. After release, a new req[0] is served with normal latency.

Source files
------------

// File: rtl/readback_scheduler.sv
// readback_scheduler
//   Lets up to 8 status/sensor modules share the single core->Jetson readback
//   channel. Each requester has a one-word holding register. A grant FSM offers
//   one word at a time to the link. Urgent-class channels are served first,
//   then aged channels, then the rest in round-robin order.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   req, bus_in   per-channel capture strobe and packed payloads
//   busy          per-channel holding register occupied
//   out_data/sel  granted payload and channel index (held until transfer)
//   out_stb       word on offer; transfer when out_stb && out_rdy
//   out_rdy       link accepts
//   urgent        registered: some urgent-class word is pending
//   overflow      sticky per-channel "request while full"; ovf_clr clears
module readback_scheduler #(
  parameter int                  CHANNELS    = 6,
  parameter int                  WIDTH       = 28,
  parameter logic [CHANNELS-1:0] URGENT_MASK = CHANNELS'(6'b000010),
  parameter int                  AGE_LIMIT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] bus_in,
  output logic [CHANNELS-1:0]       busy,
  output logic [WIDTH-1:0]          out_data,
  output logic [2:0]                out_sel,
  output logic                      out_stb,
  input  logic                      out_rdy,
  output logic                      urgent,
  output logic [CHANNELS-1:0]       overflow,
  input  logic                      ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
  localparam logic [2:0] RR_INIT = 3'(CHANNELS - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hold_q [CHANNELS];
  logic [WIDTH-1:0]     hold_d [CHANNELS];
  logic [7:0]           age_q  [CHANNELS];
  logic [7:0]           age_d  [CHANNELS];
  logic [CHANNELS-1:0]  busy_q, busy_d;
  logic [CHANNELS-1:0]  overflow_q, overflow_d;
  logic [2:0]           rr_q, rr_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [2:0]           out_sel_q, out_sel_d;
  logic                 out_stb_q, out_stb_d;
  logic                 urgent_q, urgent_d;
  logic                 grant_rr_q, grant_rr_d;

  logic                 xfer;
  logic [CHANNELS-1:0]  on_offer;
  logic [CHANNELS-1:0]  aged;
  logic                 found;
  logic [2:0]           win_idx;
  logic                 win_rr;
  int unsigned          rr_idx;

  assign xfer = (state_q == OFFER) && out_stb_q && out_rdy;

  always_comb begin
    on_offer = '0;
    aged     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      on_offer[i] = (state_q == OFFER) && (out_sel_q == 3'(i));
      aged[i]     = (age_q[i] == AGE_MAX);
    end
  end

  // Winner selection: urgent, then aged, then round-robin after rr_q.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_rr  = 1'b0;
    rr_idx  = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!found && busy_q[i] && URGENT_MASK[i]) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!found && busy_q[i] && aged[i]) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      rr_idx = (32'(rr_q) + k) % CHANNELS;
      if (!found && busy_q[rr_idx]) begin
        found   = 1'b1;
        win_idx = 3'(rr_idx);
        win_rr  = 1'b1;
      end
    end
  end

  // Holding registers, busy, overflow and age counters.
  always_comb begin
    busy_d     = busy_q;
    overflow_d = ovf_clr ? '0 : overflow_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hold_d[i] = hold_q[i];
      age_d[i]  = age_q[i];
      // A word leaving this cycle frees the slot for a same-cycle capture.
      if (req[i]) begin
        if (!busy_q[i] || (xfer && out_sel_q == 3'(i))) begin
          hold_d[i] = bus_in[i*WIDTH +: WIDTH];
          busy_d[i] = 1'b1;
        end else begin
          overflow_d[i] = 1'b1;
        end
      end else if (xfer && out_sel_q == 3'(i)) begin
        busy_d[i] = 1'b0;
      end
      if (!busy_q[i]) begin
        age_d[i] = '0;
      end else if (!on_offer[i] && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 8'd1;
      end
    end
  end

  // Grant FSM next-state and output registers.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_stb_d  = out_stb_q;
    grant_rr_d = grant_rr_q;
    rr_d       = rr_q;
    urgent_d   = |(busy_q & URGENT_MASK);
    case (state_q)
      IDLE: begin
        if (found) begin
          out_data_d = hold_q[win_idx];
          out_sel_d  = win_idx;
          out_stb_d  = 1'b1;
          grant_rr_d = win_rr;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (xfer) begin
          out_stb_d = 1'b0;
          if (grant_rr_q) rr_d = out_sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      overflow_q <= '0;
      rr_q       <= RR_INIT;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_stb_q  <= 1'b0;
      urgent_q   <= 1'b0;
      grant_rr_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      rr_q       <= rr_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      out_stb_q  <= out_stb_d;
      urgent_q   <= urgent_d;
      grant_rr_q <= grant_rr_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= hold_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;
  assign out_stb  = out_stb_q;
  assign urgent   = urgent_q;

endmodule
